// File: rtl/estacionamiento_ctrl_if.sv
// Parking controller bus: lane sensors in, occupancy/status out.
interface estacionamiento_ctrl_if;
    logic       ent_a;
    logic       ent_b;
    logic       sal_a;
    logic       sal_b;
    logic [3:0] ocupacion;
    logic       lleno;
    logic       barrera_ent;
    logic       hubo_error;

    // Sensor side / observer (e.g. the environment driving the lanes)
    modport master (
        output ent_a, ent_b, sal_a, sal_b,
        input  ocupacion, lleno, barrera_ent, hubo_error
    );

    // Controller side
    modport slave (
        input  ent_a, ent_b, sal_a, sal_b,
        output ocupacion, lleno, barrera_ent, hubo_error
    );
endinterface

// File: rtl/estacionamiento_ctrl.sv
// Parking lot occupancy controller: two identical two-sensor lane FSMs
// (entry, exit) detect complete traversals; a saturating counter tracks
// occupancy and a sticky flag records sequencing or count errors.
module estacionamiento_ctrl #(
    parameter int CAPACIDAD = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    estacionamiento_ctrl_if.slave bus
);

    localparam logic [3:0] CAP = 4'(CAPACIDAD);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        S_A   = 3'd1,
        S_AB  = 3'd2,
        S_B   = 3'd3,
        ABORT = 3'd4
    } lane_state_t;

    // Lane 0 = entry, lane 1 = exit; each pattern packed as {a, b}
    logic [1:0][1:0] lane_ab;
    logic [1:0]      lane_pass;
    logic [1:0]      lane_err;

    assign lane_ab[0] = {bus.ent_a, bus.ent_b};
    assign lane_ab[1] = {bus.sal_a, bus.sal_b};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lane
            lane_state_t state_reg;

            // Lane traversal FSM: a vehicle must go a -> ab -> b -> clear
            always_ff @(posedge clk) begin
                if (reset) begin
                    state_reg <= IDLE;
                end else begin
                    case (state_reg)
                        IDLE: begin
                            case (lane_ab[gi])
                                2'b10:   state_reg <= S_A;
                                2'b01:   state_reg <= ABORT;
                                2'b11:   state_reg <= ABORT;
                                default: state_reg <= IDLE;
                            endcase
                        end
                        S_A: begin
                            case (lane_ab[gi])
                                2'b11:   state_reg <= S_AB;
                                2'b00:   state_reg <= IDLE;
                                2'b01:   state_reg <= ABORT;
                                default: state_reg <= S_A;
                            endcase
                        end
                        S_AB: begin
                            case (lane_ab[gi])
                                2'b01:   state_reg <= S_B;
                                2'b10:   state_reg <= S_A;
                                2'b00:   state_reg <= ABORT;
                                default: state_reg <= S_AB;
                            endcase
                        end
                        S_B: begin
                            case (lane_ab[gi])
                                2'b11:   state_reg <= S_AB;
                                2'b00:   state_reg <= IDLE;
                                2'b10:   state_reg <= ABORT;
                                default: state_reg <= S_B;
                            endcase
                        end
                        default: begin
                            // ABORT waits for the lane to clear before rearming
                            state_reg <= (lane_ab[gi] == 2'b00) ? IDLE : ABORT;
                        end
                    endcase
                end
            end

            // Pass pulse and sequencing error are decoded from the current
            // state and sensors so the counter reacts on the same edge.
            assign lane_pass[gi] = (state_reg == S_B) && (lane_ab[gi] == 2'b00);
            assign lane_err[gi]  = ((state_reg == IDLE) && (lane_ab[gi] == 2'b11)) ||
                                   ((state_reg == S_A)  && (lane_ab[gi] == 2'b01)) ||
                                   ((state_reg == S_AB) && (lane_ab[gi] == 2'b00)) ||
                                   ((state_reg == S_B)  && (lane_ab[gi] == 2'b10));
        end
    endgenerate

    logic [3:0] ocupacion_reg;
    logic [3:0] ocupacion_next;
    logic       hubo_error_reg;
    logic       cnt_err;

    // Occupancy update: simultaneous passes cancel; limits saturate and flag
    always_comb begin
        ocupacion_next = ocupacion_reg;
        cnt_err        = 1'b0;
        if (lane_pass[0] && !lane_pass[1]) begin
            if (ocupacion_reg == CAP) begin
                cnt_err = 1'b1;
            end else begin
                ocupacion_next = ocupacion_reg + 4'd1;
            end
        end else if (lane_pass[1] && !lane_pass[0]) begin
            if (ocupacion_reg == 4'd0) begin
                cnt_err = 1'b1;
            end else begin
                ocupacion_next = ocupacion_reg - 4'd1;
            end
        end
    end

    // Counter and sticky error register
    always_ff @(posedge clk) begin
        if (reset) begin
            ocupacion_reg  <= 4'd0;
            hubo_error_reg <= 1'b0;
        end else begin
            ocupacion_reg  <= ocupacion_next;
            hubo_error_reg <= hubo_error_reg | (|lane_err) | cnt_err;
        end
    end

    assign bus.ocupacion   = ocupacion_reg;
    assign bus.hubo_error  = hubo_error_reg;
    assign bus.lleno       = (ocupacion_reg == CAP);
    assign bus.barrera_ent = (ocupacion_reg != CAP);

endmodule

// File: tb/tb_estacionamiento_ctrl.sv
// Directed bench for estacionamiento_ctrl: each step drives reset and both
// lanes, pushes the expected post-edge status to a scoreboard queue, then
// pops and compares it against the DUT one time unit after the edge.
module tb_estacionamiento_ctrl;

    localparam int CAP = 12;

    logic clk;
    logic reset;

    estacionamiento_ctrl_if bus ();

    estacionamiento_ctrl #(.CAPACIDAD(CAP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [3:0] o;
        logic       l;
        logic       b;
        logic       e;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Bench-side expected state, advanced by the stimulus tasks below
    int   model_o;
    logic model_e;

    task automatic step(input string tag, input logic rst,
                        input logic [1:0] e, input logic [1:0] s);
        exp_t x;
        exp_t got;
        reset = rst;
        {bus.ent_a, bus.ent_b} = e;
        {bus.sal_a, bus.sal_b} = s;
        x.tag = tag;
        x.o   = 4'(model_o);
        x.l   = (model_o == CAP);
        x.b   = (model_o != CAP);
        x.e   = model_e;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        checks++;
        assert (bus.ocupacion === got.o) else begin
            errors++;
            $error("FAIL %s ocupacion got %0d expected %0d", got.tag, bus.ocupacion, got.o);
        end
        checks++;
        assert (bus.lleno === got.l) else begin
            errors++;
            $error("FAIL %s lleno got %b expected %b", got.tag, bus.lleno, got.l);
        end
        checks++;
        assert (bus.barrera_ent === got.b) else begin
            errors++;
            $error("FAIL %s barrera_ent got %b expected %b", got.tag, bus.barrera_ent, got.b);
        end
        checks++;
        assert (bus.hubo_error === got.e) else begin
            errors++;
            $error("FAIL %s hubo_error got %b expected %b", got.tag, bus.hubo_error, got.e);
        end
        $display("step %-10s rst=%b ent=%b sal=%b -> ocup=%0d lleno=%b barrera=%b err=%b",
                 tag, rst, e, s, bus.ocupacion, bus.lleno, bus.barrera_ent, bus.hubo_error);
    endtask

    task automatic do_reset(input string tag);
        model_o = 0;
        model_e = 1'b0;
        step(tag, 1'b1, 2'b00, 2'b00);
    endtask

    // Full valid traversal on the selected lane(s); count changes only on
    // the final 00 step, following the saturate/cancel rules.
    task automatic traverse(input string tag, input bit ent, input bit sal);
        logic [1:0] pat [4];
        pat[0] = 2'b10; pat[1] = 2'b11; pat[2] = 2'b01; pat[3] = 2'b00;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                if (ent && !sal) begin
                    if (model_o == CAP) model_e = 1'b1;
                    else model_o = model_o + 1;
                end else if (sal && !ent) begin
                    if (model_o == 0) model_e = 1'b1;
                    else model_o = model_o - 1;
                end
            end
            step(tag, 1'b0, ent ? pat[i] : 2'b00, sal ? pat[i] : 2'b00);
        end
    endtask

    initial begin
        reset = 1'b1;
        {bus.ent_a, bus.ent_b, bus.sal_a, bus.sal_b} = 4'b0000;

        // Reset state
        do_reset("reset");
        do_reset("reset");

        // Single entry from reset
        step("idle", 1'b0, 2'b00, 2'b00);
        traverse("entry1", 1'b1, 1'b0);

        // Back-out then reverse traversal: no count, no error
        step("backout", 1'b0, 2'b10, 2'b00);
        step("backout", 1'b0, 2'b00, 2'b00);
        step("reverse", 1'b0, 2'b01, 2'b00);
        step("reverse", 1'b0, 2'b11, 2'b00);
        step("reverse", 1'b0, 2'b10, 2'b00);
        step("reverse", 1'b0, 2'b00, 2'b00);
        traverse("after_rev", 1'b1, 1'b0);   // proves lane back in IDLE

        // Skip error: IDLE sees 11 directly
        model_e = 1'b1;
        step("skip", 1'b0, 2'b11, 2'b00);
        step("skip", 1'b0, 2'b00, 2'b00);
        traverse("post_err", 1'b1, 1'b0);    // counting continues after error

        // Fill to capacity, then overflow
        do_reset("rst_full");
        for (int k = 0; k < CAP; k++) traverse("fill", 1'b1, 1'b0);
        traverse("overflow", 1'b1, 1'b0);
        traverse("exit_full", 1'b0, 1'b1);

        // Simultaneous passes at 5, then drain and underflow
        do_reset("rst_sim");
        for (int k = 0; k < 5; k++) traverse("to5", 1'b1, 1'b0);
        traverse("simul", 1'b1, 1'b1);
        for (int k = 0; k < 5; k++) traverse("drain", 1'b0, 1'b1);
        traverse("underflow", 1'b0, 1'b1);

        // Reset while entry lane is in S_AB at occupancy 7
        do_reset("rst_mid");
        for (int k = 0; k < 7; k++) traverse("to7", 1'b1, 1'b0);
        step("mid", 1'b0, 2'b10, 2'b00);
        step("mid", 1'b0, 2'b11, 2'b00);
        model_o = 0;
        model_e = 1'b0;
        step("mid_rst", 1'b1, 2'b11, 2'b00);
        step("residual", 1'b0, 2'b01, 2'b00);
        step("residual", 1'b0, 2'b00, 2'b00);
        traverse("fresh", 1'b1, 1'b0);

        // Exit-lane sequencing error: S_AB sees 00
        step("exit_err", 1'b0, 2'b00, 2'b10);
        step("exit_err", 1'b0, 2'b00, 2'b11);
        model_e = 1'b1;
        step("exit_err", 1'b0, 2'b00, 2'b00);
        step("exit_err", 1'b0, 2'b00, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/estacionamiento_ctrl.md
ESTACIONAMIENTO_CTRL -- requirements
Module: estacionamiento_ctrl

Interface
REQ-001 Parameter CAPACIDAD, default 12: maximum occupancy, legal range 1..15.
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 ent_a  input  1  entry-lane outer sensor, already debounced, 1 = blocked.
REQ-005 ent_b  input  1  entry-lane inner sensor, already debounced, 1 = blocked.
REQ-006 sal_a  input  1  exit-lane inner sensor, already debounced, 1 = blocked.
REQ-007 sal_b  input  1  exit-lane outer sensor, already debounced, 1 = blocked.
REQ-008 ocupacion  output  4  current vehicle count, registered.
REQ-009 lleno  output  1  high when ocupacion == CAPACIDAD.
REQ-010 barrera_ent  output  1  entry gate open request; equals !lleno.
REQ-011 hubo_error  output  1  sticky error flag, registered.

Function
REQ-012 Each lane (entry: a=ent_a, b=ent_b; exit: a=sal_a, b=sal_b) SHALL run an identical, independent 5-state FSM: IDLE, S_A, S_AB, S_B, ABORT. Input pattern is written ab.
REQ-013 IDLE transitions: 00 -> IDLE; 10 -> S_A; 01 -> ABORT (reverse traversal, no error); 11 -> ABORT with error.
REQ-014 S_A transitions: 10 -> S_A; 11 -> S_AB; 00 -> IDLE (backed out, no count); 01 -> ABORT with error.
REQ-015 S_AB transitions: 11 -> S_AB; 01 -> S_B; 10 -> S_A (backing up); 00 -> ABORT with error.
REQ-016 S_B transitions: 01 -> S_B; 11 -> S_AB; 00 -> IDLE with a one-cycle pass pulse; 10 -> ABORT with error.
REQ-017 ABORT transitions: 00 -> IDLE; any other pattern -> ABORT. No pass pulse and no error originate in ABORT.
REQ-018 The pass pulse SHALL be combinational from (state == S_B && ab == 00). ocupacion SHALL update on the same edge that the FSM returns to IDLE, i.e. one clock after the sensors read 00.
REQ-019 Counter update on each edge: entry pass only -> +1; exit pass only -> -1; both passes in the same cycle -> unchanged with no error; neither -> unchanged.
REQ-020 Entry pass only while ocupacion == CAPACIDAD: ocupacion stays at CAPACIDAD (saturates) and hubo_error SHALL be set.
REQ-021 Exit pass only while ocupacion == 0: ocupacion stays at 0 (no wrap to 15) and hubo_error SHALL be set.
REQ-022 hubo_error SHALL be set on the edge following any error condition in REQ-013..016, REQ-020 or REQ-021, and SHALL remain 1 until reset.
REQ-023 An error SHALL NOT stop counting; the lanes and the counter keep operating normally.
REQ-024 lleno and barrera_ent SHALL be derived combinationally from the registered ocupacion, so they reflect a change in the same cycle ocupacion changes.

Reset
REQ-025 When reset is high on a rising edge, the following SHALL hold on that edge, overriding all other activity including pending pass pulses: both FSMs -> IDLE, ocupacion = 0, hubo_error = 0. Consequently lleno = 0 and barrera_ent = 1.
REQ-026 If reset is asserted mid-traversal, the lane returns to IDLE. A later 00 -> 10 sequence starts a fresh traversal. Residual patterns seen in IDLE follow REQ-013.

Verification
REQ-027 Single entry: ent ab = 00,10,11,01,00, one cycle each, from reset -> ocupacion 0->1 on the edge after the 00 sample; hubo_error = 0.
REQ-028 Back-out and reverse: entry 10,00, then 01,11,10,00 -> ocupacion stays 0, hubo_error = 0, FSM ends in IDLE.
REQ-029 Skip error: entry 00->11 directly, then 00 -> hubo_error = 1 one edge later, ocupacion unchanged. A subsequent valid entry still increments.
REQ-030 Full and overflow, CAPACIDAD = 12: 12 valid entries -> ocupacion = 12, lleno = 1, barrera_ent = 0. A 13th entry -> ocupacion stays 12, hubo_error = 1.
REQ-031 Simultaneous passes: ocupacion = 5, entry and exit reach the S_B->00 step in the same cycle -> ocupacion stays 5, no error. Exit pass at 0 -> ocupacion stays 0, hubo_error = 1.
REQ-032 Reset mid-operation: reset pulsed while entry is in S_AB with ocupacion = 7 -> next cycle ocupacion = 0, hubo_error = 0. Continuing 01,00 on the entry lane produces no increment.
